wvb_rd_arbiter: RTL and testbench

//  Round-robin readout scheduler sharing one waveform-buffer read port among P_N_CHAN

---
 rtl/wvb_rd_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_wvb_rd_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wvb_rd_arbiter.sv
// Round-robin readout scheduler: grants one channel's pending header, walks its waveform
// buffer from start to stop address and streams the samples through a 4-entry output FIFO.
module wvb_rd_arbiter #(
  parameter int unsigned P_N_CHAN     = 8,
  parameter int unsigned P_CHAN_WIDTH = 3,
  parameter int unsigned P_DATA_WIDTH = 22,
  parameter int unsigned P_ADR_WIDTH  = 12,
  parameter int unsigned P_HDR_WIDTH  = 80
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic [P_N_CHAN-1:0]               hdr_empty,
  input  logic [P_N_CHAN*P_HDR_WIDTH-1:0]   hdr_data,
  input  logic [P_N_CHAN*P_ADR_WIDTH-1:0]   hdr_start,
  input  logic [P_N_CHAN*P_ADR_WIDTH-1:0]   hdr_stop,
  output logic [P_N_CHAN-1:0]               hdr_rdreq,
  output logic [P_ADR_WIDTH-1:0]            wvb_rd_addr,
  output logic [P_CHAN_WIDTH-1:0]           wvb_rd_sel,
  input  logic [P_N_CHAN*P_DATA_WIDTH-1:0]  wvb_rd_data,
  output logic [P_HDR_WIDTH-1:0]            evt_hdr,
  output logic [P_CHAN_WIDTH-1:0]           evt_chan,
  output logic                              evt_start,
  output logic [P_DATA_WIDTH-1:0]           dout_data,
  output logic                              dout_valid,
  input  logic                              dout_ready,
  output logic                              dout_eof,
  output logic [P_N_CHAN-1:0]               rd_done,
  output logic                              busy
);

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CNT_W      = 3;
  localparam logic [P_CHAN_WIDTH:0]   N_CHAN_W = (P_CHAN_WIDTH+1)'(P_N_CHAN);
  localparam logic [P_CHAN_WIDTH-1:0] LAST_CH  = P_CHAN_WIDTH'(P_N_CHAN - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t state, state_nxt;

  logic [P_HDR_WIDTH-1:0]  hdr_arr   [P_N_CHAN];
  logic [P_ADR_WIDTH-1:0]  start_arr [P_N_CHAN];
  logic [P_ADR_WIDTH-1:0]  stop_arr  [P_N_CHAN];
  logic [P_DATA_WIDTH-1:0] rd_arr    [P_N_CHAN];

  for (genvar g = 0; g < P_N_CHAN; g++) begin : g_unpack
    assign hdr_arr[g]   = hdr_data[g*P_HDR_WIDTH +: P_HDR_WIDTH];
    assign start_arr[g] = hdr_start[g*P_ADR_WIDTH +: P_ADR_WIDTH];
    assign stop_arr[g]  = hdr_stop[g*P_ADR_WIDTH +: P_ADR_WIDTH];
    assign rd_arr[g]    = wvb_rd_data[g*P_DATA_WIDTH +: P_DATA_WIDTH];
  end

  logic [P_CHAN_WIDTH-1:0] rr_ptr;
  logic [P_ADR_WIDTH-1:0]  remaining;
  logic                    p1_vld, p1_eof, p2_vld, p2_eof;
  logic [CNT_W-1:0]        occ, occ_nxt, outstanding;
  logic [P_DATA_WIDTH-1:0] fifo_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   fifo_e;

  logic                    gnt_vld, grant, credit, issue, last, pop, wr;
  logic [P_CHAN_WIDTH-1:0] gnt_chan;
  logic [P_CHAN_WIDTH:0]   cand;
  logic [1:0]              widx;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Round-robin search, credit check and next-state decode
  always_comb begin
    state_nxt   = state;
    gnt_vld     = 1'b0;
    gnt_chan    = '0;
    cand        = '0;
    issue       = 1'b0;
    last        = 1'b0;
    outstanding = occ + CNT_W'(p1_vld) + CNT_W'(p2_vld);
    credit      = (outstanding < CNT_W'(FIFO_DEPTH));
    for (int unsigned i = 0; i < P_N_CHAN; i++) begin
      cand = {1'b0, rr_ptr} + (P_CHAN_WIDTH+1)'(i);
      if (cand >= N_CHAN_W) cand = cand - N_CHAN_W;
      if (!gnt_vld && !hdr_empty[cand[P_CHAN_WIDTH-1:0]]) begin
        gnt_vld  = 1'b1;
        gnt_chan = cand[P_CHAN_WIDTH-1:0];
      end
    end
    grant = (state == S_IDLE) && en && gnt_vld;
    case (state)
      S_IDLE:  if (grant) state_nxt = S_READ;
      S_READ: begin
        if (credit) begin
          issue = 1'b1;
          if (remaining == '0) begin
            last      = 1'b1;
            state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: if (!p1_vld && !p2_vld) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant latch, address walk and read pipeline tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_rdreq   <= '0;
      evt_start   <= 1'b0;
      evt_hdr     <= '0;
      evt_chan    <= '0;
      wvb_rd_sel  <= '0;
      wvb_rd_addr <= '0;
      remaining   <= '0;
      rr_ptr      <= '0;
      rd_done     <= '0;
      p1_vld      <= 1'b0;
      p1_eof      <= 1'b0;
      p2_vld      <= 1'b0;
      p2_eof      <= 1'b0;
    end else begin
      hdr_rdreq <= '0;
      evt_start <= 1'b0;
      rd_done   <= '0;
      if (grant) begin
        hdr_rdreq   <= P_N_CHAN'(1) << gnt_chan;
        evt_start   <= 1'b1;
        evt_hdr     <= hdr_arr[gnt_chan];
        evt_chan    <= gnt_chan;
        wvb_rd_sel  <= gnt_chan;
        wvb_rd_addr <= start_arr[gnt_chan];
        remaining   <= stop_arr[gnt_chan] - start_arr[gnt_chan];
        rr_ptr      <= (gnt_chan == LAST_CH) ? '0 : gnt_chan + P_CHAN_WIDTH'(1);
      end
      if (issue) begin
        wvb_rd_addr <= wvb_rd_addr + P_ADR_WIDTH'(1);
        if (last) rd_done   <= P_N_CHAN'(1) << wvb_rd_sel;
        else      remaining <= remaining - P_ADR_WIDTH'(1);
      end
      p1_vld <= issue;
      p1_eof <= last;
      p2_vld <= p1_vld;
      p2_eof <= p1_eof;
    end
  end

  assign wr      = p2_vld;
  assign pop     = dout_valid && dout_ready;
  assign occ_nxt = occ + CNT_W'(wr) - CNT_W'(pop);
  assign widx    = pop ? 2'(occ - CNT_W'(1)) : 2'(occ);

  // Shifting output FIFO: entry 0 is always the head, so outputs come straight off flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_d[i] <= '0;
      fifo_e     <= '0;
      occ        <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (pop) begin
        for (int i = 0; i < FIFO_DEPTH-1; i++) begin
          fifo_d[i] <= fifo_d[i+1];
          fifo_e[i] <= fifo_e[i+1];
        end
      end
      if (wr) begin
        fifo_d[widx] <= rd_arr[wvb_rd_sel];
        fifo_e[widx] <= p2_eof;
      end
      occ        <= occ_nxt;
      dout_valid <= (occ_nxt != '0);
      busy       <= (state_nxt != S_IDLE) || (occ_nxt != '0);
    end
  end

  assign dout_data = fifo_d[0];
  assign dout_eof  = fifo_e[0];

endmodule

// File: tb/tb_wvb_rd_arbiter.sv
// Directed bench for wvb_rd_arbiter with header-FIFO and 2-cycle wvb models.
module tb_wvb_rd_arbiter;
  localparam int N = 8;
  localparam int CW = 3;
  localparam int DW = 22;
  localparam int AW = 12;
  localparam int HW = 80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic dout_ready = 1'b1;
  logic [N-1:0]    hdr_empty;
  logic [N*HW-1:0] hdr_data;
  logic [N*AW-1:0] hdr_start, hdr_stop;
  logic [N-1:0]    hdr_rdreq;
  logic [AW-1:0]   wvb_rd_addr;
  logic [CW-1:0]   wvb_rd_sel;
  logic [N*DW-1:0] wvb_rd_data;
  logic [HW-1:0]   evt_hdr;
  logic [CW-1:0]   evt_chan;
  logic            evt_start;
  logic [DW-1:0]   dout_data;
  logic            dout_valid, dout_eof, busy;
  logic [N-1:0]    rd_done;

  wvb_rd_arbiter dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hdr_empty(hdr_empty), .hdr_data(hdr_data),
    .hdr_start(hdr_start), .hdr_stop(hdr_stop), .hdr_rdreq(hdr_rdreq),
    .wvb_rd_addr(wvb_rd_addr), .wvb_rd_sel(wvb_rd_sel), .wvb_rd_data(wvb_rd_data),
    .evt_hdr(evt_hdr), .evt_chan(evt_chan), .evt_start(evt_start),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_eof(dout_eof), .rd_done(rd_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Header FIFO model: per-channel array with head/tail pointers
  int q_head [N];
  int q_tail [N];
  logic [AW-1:0] q_sa [N][16];
  logic [AW-1:0] q_so [N][16];

  initial for (int c = 0; c < N; c++) begin q_head[c] = 0; q_tail[c] = 0; end

  function automatic logic [HW-1:0] mk_hdr(input int c, input logic [AW-1:0] s, input logic [AW-1:0] e);
    return {56'(c + 1), s, e};
  endfunction

  function automatic logic [DW-1:0] smp(input int c, input logic [AW-1:0] a);
    return {4'(c), 6'h2A, a};
  endfunction

  always_comb begin
    for (int c = 0; c < N; c++) begin
      hdr_empty[c]            = (q_head[c] == q_tail[c]);
      hdr_start[c*AW +: AW]   = q_sa[c][q_head[c] & 15];
      hdr_stop[c*AW +: AW]    = q_so[c][q_head[c] & 15];
      hdr_data[c*HW +: HW]    = mk_hdr(c, q_sa[c][q_head[c] & 15], q_so[c][q_head[c] & 15]);
    end
  end

  always @(posedge clk)
    for (int c = 0; c < N; c++) if (hdr_rdreq[c]) q_head[c] <= q_head[c] + 1;

  // Two-cycle wvb read model
  logic [AW-1:0] a1 = '0, a2 = '0;
  always @(posedge clk) begin a1 <= wvb_rd_addr; a2 <= a1; end
  always_comb for (int c = 0; c < N; c++) wvb_rd_data[c*DW +: DW] = smp(c, a2);

  // Monitors
  logic [DW-1:0] rx_d [$];
  logic          rx_e [$];
  int            g_q  [$];
  int            done_cnt [N];
  int            stall_err = 0;
  int            stall_seen = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] held_d = '0;
  logic          held_e = 1'b0;

  initial for (int c = 0; c < N; c++) done_cnt[c] = 0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (dout_valid && dout_ready) begin rx_d.push_back(dout_data); rx_e.push_back(dout_eof); end
      if (evt_start) g_q.push_back(int'(evt_chan));
      for (int c = 0; c < N; c++) if (rd_done[c]) done_cnt[c] <= done_cnt[c] + 1;
      if (prev_stall) begin
        stall_seen <= stall_seen + 1;
        if (!dout_valid || dout_data !== held_d || dout_eof !== held_e) stall_err <= stall_err + 1;
      end
    end
    prev_stall <= rst_n && dout_valid && !dout_ready;
    held_d     <= dout_data;
    held_e     <= dout_eof;
  end

  logic [DW-1:0] exp_d [$];
  logic          exp_e [$];

  task automatic push(input int c, input logic [AW-1:0] s, input logic [AW-1:0] e);
    q_sa[c][q_tail[c] & 15] = s;
    q_so[c][q_tail[c] & 15] = e;
    q_tail[c] = q_tail[c] + 1;
  endtask

  task automatic add_exp(input int c, input logic [AW-1:0] s, input logic [AW-1:0] e);
    int n;
    logic [AW-1:0] a;
    n = int'(AW'(e - s)) + 1;
    for (int i = 0; i < n; i++) begin
      a = s + AW'(i);
      exp_d.push_back(smp(c, a));
      exp_e.push_back(i == n - 1);
    end
  endtask

  task automatic check_stream(input string tag);
    int m;
    chk({tag, "_nsamp"}, 96'(rx_d.size()), 96'(exp_d.size()));
    m = (rx_d.size() < exp_d.size()) ? rx_d.size() : exp_d.size();
    for (int i = 0; i < m; i++) chk(tag, {rx_e[i], rx_d[i]}, {exp_e[i], exp_d[i]});
    rx_d.delete(); rx_e.delete(); exp_d.delete(); exp_e.delete();
  endtask

  task automatic wait_done(input bit toggle);
    int idle_n = 0;
    int k = 0;
    while (idle_n < 2 && k < 3000) begin
      @(negedge clk);
      k++;
      if (toggle) dout_ready = ~dout_ready;
      if (!busy && (&hdr_empty)) idle_n++;
      else idle_n = 0;
    end
    dout_ready = 1'b1;
    chk("done_in_budget", 96'(idle_n >= 2), 96'(1));
  endtask

  task automatic wait_evt(output bit seen);
    int k = 0;
    seen = 1'b0;
    while (!seen && k < 50) begin
      @(negedge clk);
      k++;
      seen = evt_start;
    end
    chk("evt_start_seen", 96'(seen), 96'(1));
  endtask

  initial begin
    bit seen;
    int k;
    int d0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 96'(dout_valid), 96'(0));
    chk("rst_busy", 96'(busy), 96'(0));
    chk("rst_rdreq", 96'(hdr_rdreq), 96'(0));
    chk("rst_addr", 96'(wvb_rd_addr), 96'(0));
    chk("rst_evt", 96'({evt_start, rd_done}), 96'(0));
    rst_n = 1'b1;
    en = 1'b1;
    @(negedge clk);

    // 1: basic event on ch0, latency and header handling
    d0 = done_cnt[0];
    push(0, 12'h010, 12'h013);
    add_exp(0, 12'h010, 12'h013);
    wait_evt(seen);
    chk("t1_rdreq", 96'(hdr_rdreq), 96'(8'h01));
    chk("t1_chan", 96'(evt_chan), 96'(0));
    chk("t1_hdr", 96'(evt_hdr), 96'(mk_hdr(0, 12'h010, 12'h013)));
    chk("t1_sel", 96'(wvb_rd_sel), 96'(0));
    k = 0;
    while (!dout_valid && k < 10) begin
      @(negedge clk);
      k++;
      if (k == 1) chk("t1_rdreq_1cyc", 96'(hdr_rdreq), 96'(0));
    end
    chk("t1_latency", 96'(k), 96'(3));
    wait_done(1'b0);
    check_stream("t1_data");
    chk("t1_rd_done", 96'(done_cnt[0] - d0), 96'(1));

    // 2: address wrap
    push(0, 12'hFFE, 12'h001);
    add_exp(0, 12'hFFE, 12'h001);
    wait_done(1'b0);
    check_stream("t2_wrap");

    // 3: round-robin order from rr_ptr=3
    push(2, 12'h020, 12'h020);
    add_exp(2, 12'h020, 12'h020);
    wait_done(1'b0);
    g_q.delete();
    en = 1'b0;
    push(2, 12'h030, 12'h031);
    push(5, 12'h050, 12'h050);
    push(5, 12'h051, 12'h052);
    push(7, 12'h070, 12'h070);
    add_exp(5, 12'h050, 12'h050);
    add_exp(7, 12'h070, 12'h070);
    add_exp(2, 12'h030, 12'h031);
    add_exp(5, 12'h051, 12'h052);
    @(negedge clk);
    en = 1'b1;
    wait_done(1'b0);
    chk("t3_ngrant", 96'(g_q.size()), 96'(4));
    if (g_q.size() == 4) begin
      chk("t3_g0", 96'(g_q[0]), 96'(5));
      chk("t3_g1", 96'(g_q[1]), 96'(7));
      chk("t3_g2", 96'(g_q[2]), 96'(2));
      chk("t3_g3", 96'(g_q[3]), 96'(5));
    end
    check_stream("t3_data");

    // 4: 16-sample event with toggling dout_ready
    push(3, 12'h100, 12'h10F);
    add_exp(3, 12'h100, 12'h10F);
    wait_done(1'b1);
    check_stream("t4_data");
    chk("t4_stall_stable", 96'(stall_err), 96'(0));
    chk("t4_stalls_seen", 96'(stall_seen != 0), 96'(1));

    // 5: single-sample event, en dropped mid-event with ch1 pending
    g_q.delete();
    push(6, 12'h7FF, 12'h7FF);
    add_exp(6, 12'h7FF, 12'h7FF);
    wait_evt(seen);
    en = 1'b0;
    push(1, 12'h011, 12'h012);
    repeat (20) @(negedge clk);
    chk("t5_idle", 96'(busy), 96'(0));
    chk("t5_no_grant", 96'(g_q.size()), 96'(1));
    chk("t5_ch1_pending", 96'(hdr_empty[1]), 96'(0));
    check_stream("t5_single");
    en = 1'b1;
    add_exp(1, 12'h011, 12'h012);
    wait_done(1'b0);
    chk("t5_ngrant", 96'(g_q.size()), 96'(2));
    if (g_q.size() == 2) chk("t5_g1", 96'(g_q[1]), 96'(1));
    check_stream("t5_after_en");

    // 6: reset mid-read, then ch0 wins over ch6
    push(4, 12'h200, 12'h2FF);
    wait_evt(seen);
    repeat (5) @(negedge clk);
    push(0, 12'h040, 12'h041);
    push(6, 12'h060, 12'h060);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 96'(dout_valid), 96'(0));
    chk("t6_rst_busy", 96'(busy), 96'(0));
    chk("t6_rst_addr", 96'(wvb_rd_addr), 96'(0));
    chk("t6_rst_data", 96'(dout_data), 96'(0));
    chk("t6_rst_sel", 96'({wvb_rd_sel, evt_chan, hdr_rdreq, rd_done}), 96'(0));
    repeat (2) @(negedge clk);
    rx_d.delete(); rx_e.delete(); g_q.delete();
    rst_n = 1'b1;
    add_exp(0, 12'h040, 12'h041);
    add_exp(6, 12'h060, 12'h060);
    wait_evt(seen);
    chk("t6_first_chan", 96'(evt_chan), 96'(0));
    wait_done(1'b0);
    check_stream("t6_data");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
